// File: rtl/pulse_gen_if.sv
// Control/status bundle for pulse_gen: configuration and enable in, pulse train and status out.
interface pulse_gen_if;
  logic        ena;
  logic        pulse_1s;
  logic [31:0] period;
  logic [31:0] width;
  logic        pulse;
  logic        pulse_start;
  logic        cfg_err;
  logic [31:0] npulse;

  modport master (
    output ena, pulse_1s, period, width,
    input  pulse, pulse_start, cfg_err, npulse
  );

  modport slave (
    input  ena, pulse_1s, period, width,
    output pulse, pulse_start, cfg_err, npulse
  );
endinterface

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: registered pulse with period/width in clk cycles,
// optional first-start alignment to the 1 s strobe, shadowed config reloaded per period.
module pulse_gen #(
  parameter logic [26:0] SIZE_1S = 27'd110000000,
  parameter logic        SYNC_1S = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  pulse_gen_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]  state;
  logic [31:0] cnt;
  logic [31:0] period_r;
  logic [31:0] width_r;
  logic [31:0] npulse_r;
  logic        pulse_r;
  logic        start_r;
  logic        err_r;
  logic        cfg_ok;

  always_comb begin
    cfg_ok = (bus.period >= 32'd2) &&
             (bus.period <= {5'd0, SIZE_1S}) &&
             (bus.width != '0) &&
             (bus.width < bus.period);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      period_r <= '0;
      width_r  <= '0;
      npulse_r <= '0;
      pulse_r  <= 1'b0;
      start_r  <= 1'b0;
      err_r    <= 1'b0;
    end else if (!bus.ena) begin
      // Disable aborts immediately, even mid-high phase.
      state    <= IDLE;
      cnt      <= '0;
      npulse_r <= '0;
      pulse_r  <= 1'b0;
      start_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          pulse_r <= 1'b0;
          start_r <= 1'b0;
          if (!cfg_ok) begin
            err_r <= 1'b1;
          end else begin
            err_r    <= 1'b0;
            period_r <= bus.period;
            width_r  <= bus.width;
            if (SYNC_1S) begin
              state <= ARM;
            end else begin
              state    <= RUN;
              cnt      <= 32'd1;
              pulse_r  <= 1'b1;
              start_r  <= 1'b1;
              npulse_r <= npulse_r + 32'd1;
            end
          end
        end

        ARM: begin
          err_r <= 1'b0;
          if (bus.pulse_1s) begin
            state    <= RUN;
            cnt      <= 32'd1;
            pulse_r  <= 1'b1;
            start_r  <= 1'b1;
            npulse_r <= npulse_r + 32'd1;
          end else begin
            pulse_r <= 1'b0;
            start_r <= 1'b0;
          end
        end

        RUN: begin
          if (cnt == period_r) begin
            // Last cycle of the period: revalidate live inputs for a gapless next period.
            if (cfg_ok) begin
              period_r <= bus.period;
              width_r  <= bus.width;
              cnt      <= 32'd1;
              pulse_r  <= 1'b1;
              start_r  <= 1'b1;
              err_r    <= 1'b0;
              npulse_r <= npulse_r + 32'd1;
            end else begin
              state   <= IDLE;
              cnt     <= '0;
              pulse_r <= 1'b0;
              start_r <= 1'b0;
              err_r   <= 1'b1;
            end
          end else begin
            cnt     <= cnt + 32'd1;
            pulse_r <= (cnt + 32'd1) <= width_r;
            start_r <= 1'b0;
            err_r   <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          pulse_r <= 1'b0;
          start_r <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse       = pulse_r;
  assign bus.pulse_start = start_r;
  assign bus.cfg_err     = err_r;
  assign bus.npulse      = npulse_r;

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: stimulus queues expected pulse starts, monitors pop and check them.
module tb_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pulse_gen_if f_if ();
  pulse_gen_if s_if ();

  pulse_gen #(.SYNC_1S(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (f_if.slave)
  );

  pulse_gen #(.SYNC_1S(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  typedef struct {
    int          at;
    logic [31:0] np;
    int          hi;
  } exp_t;

  exp_t fq[$];
  exp_t sq[$];

  int ec     = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) ec <= ec + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ec);
    end
  endtask

  task automatic pushf(input int at, input logic [31:0] np, input int hi);
    exp_t e;
    e.at = at; e.np = np; e.hi = hi;
    fq.push_back(e);
  endtask

  task automatic pushs(input int at, input logic [31:0] np);
    exp_t e;
    e.at = at; e.np = np; e.hi = -1;
    sq.push_back(e);
  endtask

  task automatic to_cyc(input int t);
    while (ec < t) @(negedge clk);
  endtask

  // Monitor for the free-running instance: start time, count and high width.
  int   hi_cnt = 0;
  int   hi_exp = -1;
  logic prev_p = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      hi_cnt = 0;
      hi_exp = -1;
      prev_p = 1'b0;
    end else begin
      if (f_if.pulse_start) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got start at edge %0d expected none", ec);
        end else begin
          exp_t e;
          e = fq.pop_front();
          chk("start_cycle", ec, e.at);
          chk("start_npulse", f_if.npulse, e.np);
          chk("start_with_pulse", f_if.pulse, 1'b1);
          hi_exp = e.hi;
          hi_cnt = 0;
        end
      end
      if (f_if.pulse) begin
        hi_cnt++;
      end else if (prev_p) begin
        if (hi_exp >= 0) chk("high_width", hi_cnt, hi_exp);
        hi_exp = -1;
      end
      prev_p = f_if.pulse;
    end
  end

  // Monitor for the 1 s-aligned instance.
  always @(negedge clk) begin
    if (rst && s_if.pulse_start) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sync_unexpected_start: got start at edge %0d expected none", ec);
      end else begin
        exp_t e;
        e = sq.pop_front();
        chk("sync_start_cycle", ec, e.at);
        chk("sync_start_npulse", s_if.npulse, e.np);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, edge %0d expected < 10000", ec);
    $fatal(1);
  end

  initial begin
    int b;
    f_if.ena = 0; f_if.pulse_1s = 0; f_if.period = '0; f_if.width = '0;
    s_if.ena = 0; s_if.pulse_1s = 0; s_if.period = '0; s_if.width = '0;

    repeat (3) @(negedge clk);
    chk("rst_pulse", f_if.pulse, 1'b0);
    chk("rst_start", f_if.pulse_start, 1'b0);
    chk("rst_cfg_err", f_if.cfg_err, 1'b0);
    chk("rst_npulse", f_if.npulse, 32'd0);
    chk("rst_sync_pulse", s_if.pulse, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic train, period 10 width 3.
    b = ec;
    f_if.period = 32'd10; f_if.width = 32'd3; f_if.ena = 1'b1;
    pushf(b + 1, 1, 3); pushf(b + 11, 2, 3); pushf(b + 21, 3, 3);
    to_cyc(b + 1);  chk("t1_cfg_err", f_if.cfg_err, 1'b0);
    to_cyc(b + 4);  chk("t1_low_c4", f_if.pulse, 1'b0);
    to_cyc(b + 25); f_if.ena = 1'b0;
    to_cyc(b + 26);
    chk("t1_off_pulse", f_if.pulse, 1'b0);
    chk("t1_off_npulse", f_if.npulse, 32'd0);
    @(negedge clk);

    // Mid-period reconfiguration only takes effect at the next boundary.
    b = ec;
    f_if.period = 32'd10; f_if.width = 32'd3; f_if.ena = 1'b1;
    pushf(b + 1, 1, 3); pushf(b + 11, 2, 5); pushf(b + 21, 3, 5);
    to_cyc(b + 4);  f_if.width = 32'd5;
    to_cyc(b + 27); f_if.ena = 1'b0;
    to_cyc(b + 28); chk("t3_off_npulse", f_if.npulse, 32'd0);
    @(negedge clk);

    // Illegal configurations in IDLE and at a period boundary.
    b = ec;
    f_if.period = 32'd10; f_if.width = 32'd0; f_if.ena = 1'b1;
    to_cyc(b + 1);
    chk("t4_w0_err", f_if.cfg_err, 1'b1);
    chk("t4_w0_pulse", f_if.pulse, 1'b0);
    chk("t4_w0_npulse", f_if.npulse, 32'd0);
    f_if.period = 32'd110000001; f_if.width = 32'd3;
    to_cyc(b + 2);
    chk("t4_big_err", f_if.cfg_err, 1'b1);
    chk("t4_big_pulse", f_if.pulse, 1'b0);
    f_if.period = 32'd10; f_if.width = 32'd10;
    to_cyc(b + 3);  chk("t4_weqp_err", f_if.cfg_err, 1'b1);
    f_if.period = 32'd1; f_if.width = 32'd1;
    to_cyc(b + 4);  chk("t4_p1_err", f_if.cfg_err, 1'b1);
    f_if.period = 32'd8; f_if.width = 32'd4;
    pushf(b + 5, 1, 4); pushf(b + 13, 2, 4);
    to_cyc(b + 5);
    chk("t4_ok_err", f_if.cfg_err, 1'b0);
    chk("t4_ok_pulse", f_if.pulse, 1'b1);
    to_cyc(b + 15); f_if.width = 32'd0;
    to_cyc(b + 20); chk("t4_last_err", f_if.cfg_err, 1'b0);
    to_cyc(b + 21);
    chk("t4_bnd_err", f_if.cfg_err, 1'b1);
    chk("t4_bnd_pulse", f_if.pulse, 1'b0);
    chk("t4_bnd_npulse", f_if.npulse, 32'd2);
    pushf(b + 22, 3, 4);
    f_if.width = 32'd4;
    to_cyc(b + 22); chk("t4_rest_err", f_if.cfg_err, 1'b0);
    to_cyc(b + 28); f_if.ena = 1'b0;
    to_cyc(b + 29); chk("t4_off_npulse", f_if.npulse, 32'd0);
    @(negedge clk);

    // Minimum config toggles every cycle; disable during a high phase.
    b = ec;
    f_if.period = 32'd2; f_if.width = 32'd1; f_if.ena = 1'b1;
    pushf(b + 1, 1, 1); pushf(b + 3, 2, 1); pushf(b + 5, 3, 1); pushf(b + 7, 4, -1);
    to_cyc(b + 2); chk("t5_low_c2", f_if.pulse, 1'b0);
    to_cyc(b + 7); chk("t5_high_c7", f_if.pulse, 1'b1);
    f_if.ena = 1'b0;
    to_cyc(b + 8);
    chk("t5_abort_pulse", f_if.pulse, 1'b0);
    chk("t5_abort_npulse", f_if.npulse, 32'd0);
    @(negedge clk);

    // Asynchronous reset during the first high cycle, then restart.
    b = ec;
    f_if.period = 32'd10; f_if.width = 32'd3; f_if.ena = 1'b1;
    pushf(b + 1, 1, -1);
    to_cyc(b + 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_pulse", f_if.pulse, 1'b0);
    chk("t6_rst_start", f_if.pulse_start, 1'b0);
    chk("t6_rst_err", f_if.cfg_err, 1'b0);
    chk("t6_rst_npulse", f_if.npulse, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    b = ec;
    pushf(b + 1, 1, 3); pushf(b + 11, 2, 3);
    to_cyc(b + 15); f_if.ena = 1'b0;
    to_cyc(b + 16); chk("t6_off_npulse", f_if.npulse, 32'd0);
    @(negedge clk);

    // 1 s alignment: strobe coincident with enable is not consumed; RUN ignores strobes.
    b = ec;
    s_if.period = 32'd10; s_if.width = 32'd3; s_if.ena = 1'b1; s_if.pulse_1s = 1'b1;
    pushs(b + 51, 1); pushs(b + 61, 2);
    to_cyc(b + 1);
    s_if.pulse_1s = 1'b0;
    to_cyc(b + 2);  chk("t2_arm_pulse", s_if.pulse, 1'b0);
    to_cyc(b + 30);
    chk("t2_wait_pulse", s_if.pulse, 1'b0);
    chk("t2_wait_npulse", s_if.npulse, 32'd0);
    to_cyc(b + 50); s_if.pulse_1s = 1'b1;
    to_cyc(b + 51); s_if.pulse_1s = 1'b0;
    chk("t2_rise_pulse", s_if.pulse, 1'b1);
    to_cyc(b + 55); s_if.pulse_1s = 1'b1;
    to_cyc(b + 56); s_if.pulse_1s = 1'b0;
    chk("t2_ignore_pulse", s_if.pulse, 1'b0);
    to_cyc(b + 65); s_if.ena = 1'b0;
    to_cyc(b + 66); chk("t2_off_npulse", s_if.npulse, 32'd0);

    repeat (3) @(negedge clk);
    chk("fq_drained", fq.size(), 32'd0);
    chk("sq_drained", sq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
Name: pulse_gen

Overview:
Programmable pulse-train generator, the transmit-side counterpart of the pulse period/width measurement block. It generates a registered pulse whose period and high width are given in clk cycles. Start can optionally be aligned to the 1 s timing strobe. Its output can be looped back into the measurement block for self-test.

Parameters:
SIZE_1S, 27'd110000000, maximum legal period in clk cycles (one second of clk)
SYNC_1S, 1'b0, 1 = first pulse after enable waits for pulse_1s; 0 = start immediately

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active low
ena  input  1  generator enable, level
pulse_1s  input  1  1 s timing strobe, single-cycle, synchronous to clk
period  input  32  requested period in clk cycles
width  input  32  requested high time in clk cycles
pulse  output  1  generated pulse, registered
pulse_start  output  1  one-cycle strobe, high in the same cycle pulse rises
cfg_err  output  1  high while enabled and the sampled configuration is illegal
npulse  output  32  number of periods started since enable

Behaviour:
- Reset: one clock, reset asynchronous and active low. During reset pulse=0, pulse_start=0, cfg_err=0, npulse=0, state=IDLE, counters and shadow registers = 0.
- Legal config: period >= 2, period <= SIZE_1S, 1 <= width <= period-1. Comparisons are unsigned 32-bit.
- Shadow registers period_r and width_r capture the period/width inputs only at a period boundary (defined below). Input changes mid-period never affect the current period.
- States: IDLE, ARM, RUN.
- IDLE:
  - ena=0: pulse=0, cfg_err=0, npulse=0.
  - ena=1 and config illegal: cfg_err=1, stay in IDLE, re-check every cycle.
  - ena=1 and config legal: capture shadows, cfg_err=0. Go to ARM if SYNC_1S=1, else start (see below).
- ARM: wait for pulse_1s=1, then start. ena=0 returns to IDLE.
- Start / period boundary, when a period begins:
  - next cycle: pulse=1, pulse_start=1, npulse+1, cnt=1.
  - Latency: enable or strobe sampled at cycle t gives the pulse rising edge at t+1.
- RUN:
  - cnt counts 1..period_r. pulse = 1 while cnt <= width_r, else 0.
  - So pulse is high for exactly width_r cycles and low for period_r-width_r cycles.
- At the cycle where cnt == period_r (last cycle of a period), the period/width inputs are re-validated:
  - legal: shadows reload and the next period begins at the next cycle, with no gap.
  - illegal: go to IDLE, pulse=0, cfg_err=1. When the config becomes legal again, restart through IDLE, and through ARM if SYNC_1S=1.
- pulse_1s during RUN is ignored; alignment happens only at the first start.
- ena=0 in any state: next cycle pulse=0, pulse_start=0, state IDLE, npulse=0. A high phase is aborted immediately, with no completion of the period.
- npulse wraps 0xFFFFFFFF -> 0.
- Simultaneous ena rise and pulse_1s with SYNC_1S=1: the strobe is not consumed. IDLE->ARM takes one cycle, so the next pulse_1s is required.
- Reset mid-operation: all outputs go to their reset values asynchronously. After release the block behaves as from power-up.
- Outputs are glitch-free: all are registered, with no combinational path from inputs.

Test Plan:
1. SYNC_1S=0, period=10, width=3, ena rises at cycle 0 -> pulse high cycles 1-3, low 4-10, high again 11-13. pulse_start at 1 and 11. npulse=1 at cycle 1, 2 at cycle 11.
2. SYNC_1S=1, period=10, width=3, ena=1 at cycle 0, pulse_1s at cycle 50 -> pulse low until cycle 51, rises at cycle 51. A second pulse_1s at cycle 55 has no effect (next rise at 61).
3. Reconfig mid-period: as test 1, width changed 3->5 at cycle 5 -> period at cycle 11 is high cycles 11-15. Period 1-10 is unchanged.
4. Illegal config (width=0, also period=SIZE_1S+1, also width=period): cfg_err=1 and pulse=0 with ena=1. Setting width=4, period=8 -> cfg_err clears and the pulse rises one cycle later.
5. Minimum config: period=2, width=1 -> pulse toggles every cycle. ena dropped while pulse=1 -> pulse=0 the next cycle, npulse=0.
6. Reset asserted mid-high phase -> pulse, pulse_start, cfg_err and npulse go to 0 immediately. After release with ena=1 and period=10, width=3 -> restart per test 1.
